lin_sched: RTL and testbench
============================

LIN_SCHED -- requirements
Module: lin_sched

Interface
REQ-001 Parameter N_SLOTS, default 4: number of schedule-table slots, range 2..16.
REQ-002 Parameter IFS_W, default 8: width of inter-frame delay count.
REQ-003 Parameter TO_W, default 12: width of frame timeout count.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rstn  in  1  reset, synchronous and active-low.
REQ-006 enable  in  1  schedule run; level-sensitive.
REQ-007 slot_valid  in  N_SLOTS  per-slot enable.
REQ-008 slot_pid  in  6*N_SLOTS  PID of slot k at bits [6k+5:6k].
REQ-009 slot_len  in  4*N_SLOTS  data byte count of slot k at bits [4k+3:4k]; legal values 1..8.
REQ-010 ifs_cycles  in  IFS_W  inter-frame delay in sys_clk cycles.
REQ-011 timeout_cycles  in  TO_W  per-frame timeout; 0 disables the timeout.
REQ-012 comm_tx_done  in  1  header transmitted by the commander.
REQ-013 resp_tx_done  in  1  response transmitted by the responder.
REQ-014 resp_err  in  1  responder checksum or framing error, qualified by resp_tx_done.
REQ-015 start  out  1  one-cycle commander start pulse.
REQ-016 pid_out  out  6  PID of the active slot, held from SELECT until the next SELECT.
REQ-017 len_out  out  4  byte count of the active slot, held as for pid_out.
REQ-018 slot_idx  out  $clog2(N_SLOTS)  index of the active slot.
REQ-019 inter_tx_delay  out  1  high during the inter-frame gap.
REQ-020 frame_ok  out  1  one-cycle pulse on an error-free completed frame.
REQ-021 frame_err  out  1  one-cycle pulse on a response error or timeout.
REQ-022 frame_count  out  16  count of completed frames (ok plus err).
REQ-023 err_count  out  8  count of errored frames.
REQ-024 sched_busy  out  1  high in every state except IDLE.

Function
REQ-025 The FSM SHALL have the states IDLE, SELECT, START, WAIT_HDR, WAIT_RESP and DELAY, and all outputs SHALL be registered.
REQ-026 In IDLE, with enable=1 and slot_valid non-zero, the FSM SHALL move to SELECT; otherwise it SHALL remain in IDLE.
REQ-027 In SELECT (one cycle), the FSM SHALL pick the first valid slot at index ≥ ptr, wrapping from N_SLOTS-1 to 0, latch its PID, length and index, and go to START.
REQ-028 If slot_valid becomes all-zero while in SELECT, the FSM SHALL go to IDLE without asserting start.
REQ-029 START SHALL assert start for exactly one cycle, clear the timeout timer and go to WAIT_HDR.
REQ-030 In WAIT_HDR, comm_tx_done SHALL move the FSM to WAIT_RESP without resetting the timer; resp_tx_done in this state SHALL be ignored.
REQ-031 In WAIT_RESP, resp_tx_done SHALL pulse frame_ok when resp_err=0 and frame_err when resp_err=1, increment frame_count, and go to DELAY.
REQ-032 In WAIT_HDR and WAIT_RESP, the timer SHALL increment each cycle; when it reaches timeout_cycles (non-zero), the block SHALL pulse frame_err, increment frame_count and go to DELAY.
REQ-033 If resp_tx_done and timer expiry fall in the same cycle, resp_tx_done SHALL take priority and the timeout SHALL not be counted.
REQ-034 frame_err SHALL increment err_count, which saturates at 255; frame_count SHALL wrap at 65535.
REQ-035 DELAY SHALL hold inter_tx_delay=1 for max(ifs_cycles,1) cycles.
REQ-036 On leaving DELAY, the block SHALL set ptr to slot_idx+1 (mod N_SLOTS) and go to SELECT if enable=1, otherwise to IDLE.
REQ-037 Deasserting enable mid-frame SHALL NOT abort the frame; the frame and its DELAY SHALL complete before IDLE.
REQ-038 slot_* inputs SHALL be sampled only in SELECT; changes during a frame SHALL have no effect on the active frame.

Reset
REQ-039 With rstn=0 at a clock edge, the block SHALL enter IDLE with ptr, timer and delay counter at 0 and every output at 0.
REQ-040 Reset asserted in any state SHALL abort the frame without emitting frame_ok or frame_err.

Verification
REQ-041 N_SLOTS=4, slot_valid=4'b1011, ifs_cycles=3, ideal done responses -> slot_idx sequence 0,1,3,0; start pulses exactly one cycle; inter_tx_delay high 3 cycles per gap.
REQ-042 timeout_cycles=10, comm_tx_done never asserted -> frame_err pulse 10 cycles after start; err_count=1; frame_count=1; next slot selected.
REQ-043 resp_tx_done and timer expiry in the same cycle -> frame_ok=1, frame_err=0, err_count unchanged.
REQ-044 260 consecutive resp_err frames -> err_count=255 (saturated); frame_count=260.
REQ-045 enable dropped during WAIT_HDR -> frame completes, DELAY runs, then IDLE with sched_busy=0 and no further start.
REQ-046 rstn low for one cycle during WAIT_RESP -> all outputs 0 the next cycle; no frame_ok or frame_err; after release, the first frame uses slot 0.

Source files
------------

// File: rtl/lin_sched_if.sv
// LIN frame handshake between the schedule master and the commander/responder.
// The master drives the start pulse and the active slot's PID/length and
// receives the header/response completion strobes.
interface lin_sched_if;
    logic       start;
    logic [5:0] pid_out;
    logic [3:0] len_out;
    logic       comm_tx_done;
    logic       resp_tx_done;
    logic       resp_err;

    modport master (
        output start,
        output pid_out,
        output len_out,
        input  comm_tx_done,
        input  resp_tx_done,
        input  resp_err
    );

    modport slave (
        input  start,
        input  pid_out,
        input  len_out,
        output comm_tx_done,
        output resp_tx_done,
        output resp_err
    );
endinterface

// File: rtl/lin_sched.sv
// LIN schedule-table master: walks the valid slots round-robin, launches one
// frame per slot, supervises header/response completion with an optional
// timeout, inserts the inter-frame gap and keeps frame/error statistics.
module lin_sched #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned IFS_W   = 8,
    parameter int unsigned TO_W    = 12
) (
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic [N_SLOTS-1:0]         slot_valid,
    input  logic [6*N_SLOTS-1:0]       slot_pid,
    input  logic [4*N_SLOTS-1:0]       slot_len,
    input  logic [IFS_W-1:0]           ifs_cycles,
    input  logic [TO_W-1:0]            timeout_cycles,
    lin_sched_if.master                lin,
    output logic [$clog2(N_SLOTS)-1:0] slot_idx,
    output logic                       inter_tx_delay,
    output logic                       frame_ok,
    output logic                       frame_err,
    output logic [15:0]                frame_count,
    output logic [7:0]                 err_count,
    output logic                       sched_busy
);
    localparam int unsigned IDX_W = $clog2(N_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_HDR,
        S_WAIT_RESP,
        S_DELAY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [TO_W-1:0]    timer;
    logic [TO_W-1:0]    timer_inc;
    logic [IFS_W-1:0]   dcnt;
    logic               expired;
    logic               delay_done;

    logic [N_SLOTS-1:0] ge_mask;
    logic [N_SLOTS-1:0] pick;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [5:0]         sel_pid;
    logic [3:0]         sel_len;

    logic               ok_ev;
    logic               err_ev;
    logic               start_d;
    logic               delay_d;
    logic               busy_d;
    logic [5:0]         pid_d;
    logic [3:0]         len_d;
    logic [IDX_W-1:0]   idx_d;
    logic [15:0]        fc_d;
    logic [7:0]         ec_d;

    assign timer_inc  = timer + 1'b1;
    assign expired    = (timeout_cycles != '0) && (timer_inc == timeout_cycles);
    assign delay_done = (dcnt == '0);

    // Round-robin pick: lowest valid slot at or above ptr, else lowest valid slot overall.
    always_comb begin
        ge_mask   = {N_SLOTS{1'b1}} << ptr;
        pick      = ((slot_valid & ge_mask) != '0) ? (slot_valid & ge_mask) : slot_valid;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_pid   = '0;
        sel_len   = '0;
        for (int unsigned j = 0; j < N_SLOTS; j++) begin
            if (!sel_found && pick[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
                sel_pid   = slot_pid[6*j +: 6];
                sel_len   = slot_len[4*j +: 4];
            end
        end
    end

    // State register plus slot pointer, frame timer and gap counter.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            ptr   <= '0;
            timer <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_START) begin
                timer <= '0;
            end else if (state == S_WAIT_HDR || state == S_WAIT_RESP) begin
                timer <= timer_inc;
            end
            if (state != S_DELAY && state_nxt == S_DELAY) begin
                dcnt <= (ifs_cycles == '0) ? '0 : ifs_cycles - 1'b1;
            end else if (state == S_DELAY && !delay_done) begin
                dcnt <= dcnt - 1'b1;
            end
            if (state == S_DELAY && delay_done) begin
                ptr <= (slot_idx == IDX_W'(N_SLOTS - 1)) ? '0 : slot_idx + 1'b1;
            end
        end
    end

    // Next-state decode; a response beats a same-cycle timer expiry.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (enable && slot_valid != '0) state_nxt = S_SELECT;
            S_SELECT:    state_nxt = sel_found ? S_START : S_IDLE;
            S_START:     state_nxt = S_WAIT_HDR;
            S_WAIT_HDR: begin
                if (expired)           state_nxt = S_DELAY;
                else if (lin.comm_tx_done) state_nxt = S_WAIT_RESP;
            end
            S_WAIT_RESP: if (lin.resp_tx_done || expired) state_nxt = S_DELAY;
            S_DELAY:     if (delay_done) state_nxt = enable ? S_SELECT : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of every registered output.
    always_comb begin
        ok_ev  = 1'b0;
        err_ev = 1'b0;
        unique case (state)
            S_WAIT_HDR:  err_ev = expired;
            S_WAIT_RESP: begin
                if (lin.resp_tx_done) begin
                    ok_ev  = !lin.resp_err;
                    err_ev = lin.resp_err;
                end else begin
                    err_ev = expired;
                end
            end
            default: ;
        endcase
        start_d = (state_nxt == S_START);
        delay_d = (state_nxt == S_DELAY);
        busy_d  = (state_nxt != S_IDLE);
        pid_d   = lin.pid_out;
        len_d   = lin.len_out;
        idx_d   = slot_idx;
        if (state == S_SELECT && sel_found) begin
            pid_d = sel_pid;
            len_d = sel_len;
            idx_d = sel_idx;
        end
        fc_d = (ok_ev || err_ev) ? frame_count + 16'd1 : frame_count;
        ec_d = (err_ev && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

    // Output registers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            lin.start      <= 1'b0;
            lin.pid_out    <= '0;
            lin.len_out    <= '0;
            slot_idx       <= '0;
            inter_tx_delay <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            frame_count    <= '0;
            err_count      <= '0;
            sched_busy     <= 1'b0;
        end else begin
            lin.start      <= start_d;
            lin.pid_out    <= pid_d;
            lin.len_out    <= len_d;
            slot_idx       <= idx_d;
            inter_tx_delay <= delay_d;
            frame_ok       <= ok_ev;
            frame_err      <= err_ev;
            frame_count    <= fc_d;
            err_count      <= ec_d;
            sched_busy     <= busy_d;
        end
    end
endmodule

// File: tb/tb_lin_sched.sv
// Bench for lin_sched: a directed table of frames, hand sequences for the
// timing corners, then randomized frames against a slot/statistics model.
module tb_lin_sched;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] mask;
        int           kind;     // 0 ok, 1 response error, 2 timeout
        int           exp_idx;
        int           exp_fc;
        int           exp_ec;
    } vec_t;

    logic           sys_clk = 1'b0;
    logic           rstn;
    logic           enable;
    logic [N-1:0]   slot_valid;
    logic [6*N-1:0] slot_pid;
    logic [4*N-1:0] slot_len;
    logic [7:0]     ifs_cycles;
    logic [11:0]    timeout_cycles;
    logic [1:0]     slot_idx;
    logic           inter_tx_delay;
    logic           frame_ok;
    logic           frame_err;
    logic [15:0]    frame_count;
    logic [7:0]     err_count;
    logic           sched_busy;

    lin_sched_if lin_bus();

    lin_sched #(.N_SLOTS(N), .IFS_W(8), .TO_W(12)) dut (
        .sys_clk        (sys_clk),
        .rstn           (rstn),
        .enable         (enable),
        .slot_valid     (slot_valid),
        .slot_pid       (slot_pid),
        .slot_len       (slot_len),
        .ifs_cycles     (ifs_cycles),
        .timeout_cycles (timeout_cycles),
        .lin            (lin_bus),
        .slot_idx       (slot_idx),
        .inter_tx_delay (inter_tx_delay),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .frame_count    (frame_count),
        .err_count      (err_count),
        .sched_busy     (sched_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int m_ptr, m_fc, m_ec;
    logic [5:0] pid_a [N];
    logic [3:0] len_a [N];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            slot_pid[6*i +: 6] = pid_a[i];
            slot_len[4*i +: 4] = len_a[i];
        end
    endtask

    // Reference: first valid slot at or after p, wrapping around the table.
    function automatic int next_slot(input logic [N-1:0] mask, input int p);
        for (int i = 0; i < N; i++) begin
            if (mask[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int kind, input int idx);
        m_ptr = (idx + 1) % N;
        m_fc  = (m_fc + 1) % 65536;
        if (kind != 0) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"},       lin_bus.start, 0);
        chk({tag, "_pid"},         lin_bus.pid_out, 0);
        chk({tag, "_len"},         lin_bus.len_out, 0);
        chk({tag, "_slot_idx"},    slot_idx, 0);
        chk({tag, "_delay"},       inter_tx_delay, 0);
        chk({tag, "_frame_ok"},    frame_ok, 0);
        chk({tag, "_frame_err"},   frame_err, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_err_count"},   err_count, 0);
        chk({tag, "_busy"},        sched_busy, 0);
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (lin_bus.start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("start_seen", 0, 1);
    endtask

    // One frame as seen from the commander/responder side. k counts negedges
    // after the one where start is seen; an input driven at k is sampled by
    // the DUT one posedge later, so the outcome pulse appears at k_out.
    task automatic run_frame(input int kind, input int cgap, input int rgap,
                             input bit spur, input bit drop_en, input bit scramble,
                             input int exp_idx, input int exp_fc, input int exp_ec,
                             input int exp_delay);
        bit         found;
        int         k_out, seen, dly;
        logic [5:0] epid;
        logic [3:0] elen;
        wait_start(found);
        if (!found) return;
        epid = pid_a[exp_idx];
        elen = len_a[exp_idx];
        chk("slot_idx", slot_idx, exp_idx);
        chk("pid_out", lin_bus.pid_out, epid);
        chk("len_out", lin_bus.len_out, elen);
        k_out = (kind == 2) ? int'(timeout_cycles) + 1 : cgap + rgap + 1;
        seen  = -1;
        for (int k = 1; k <= k_out + 3; k++) begin
            @(negedge sys_clk);
            lin_bus.comm_tx_done = 1'b0;
            lin_bus.resp_tx_done = 1'b0;
            lin_bus.resp_err     = 1'b0;
            if (k == 1) begin
                chk("start_width", lin_bus.start, 0);
                if (drop_en) enable = 1'b0;
                if (scramble) begin
                    slot_pid = 24'($urandom);
                    slot_len = 16'($urandom);
                end
            end
            if (frame_ok || frame_err) begin
                seen = k;
                break;
            end
            if (spur && k == 1) begin
                lin_bus.resp_tx_done = 1'b1;
                lin_bus.resp_err     = 1'b1;
            end
            if (kind != 2 && k == cgap) lin_bus.comm_tx_done = 1'b1;
            if (kind != 2 && k == cgap + rgap) begin
                lin_bus.resp_tx_done = 1'b1;
                lin_bus.resp_err     = (kind == 1);
            end
        end
        chk("outcome_cycle", seen, k_out);
        chk("frame_ok", frame_ok, kind == 0);
        chk("frame_err", frame_err, kind != 0);
        chk("pid_held", lin_bus.pid_out, epid);
        chk("len_held", lin_bus.len_out, elen);
        chk("frame_count", frame_count, exp_fc);
        chk("err_count", err_count, exp_ec);
        dly = 0;
        while (inter_tx_delay && dly < 300) begin
            dly++;
            @(negedge sys_clk);
            if (dly == 1) chk("outcome_width", frame_ok || frame_err, 0);
        end
        chk("ifs_gap", dly, exp_delay);
    endtask

    initial begin : main
        vec_t tbl [8];
        int   e, starts, kind, ifs;
        bit   found;

        tbl[0] = '{4'b1011, 0, 0, 1, 0};
        tbl[1] = '{4'b1011, 0, 1, 2, 0};
        tbl[2] = '{4'b1011, 1, 3, 3, 1};
        tbl[3] = '{4'b1011, 0, 0, 4, 1};
        tbl[4] = '{4'b1100, 2, 2, 5, 2};
        tbl[5] = '{4'b0001, 0, 0, 6, 2};
        tbl[6] = '{4'b1000, 1, 3, 7, 3};
        tbl[7] = '{4'b0110, 0, 1, 8, 3};

        rstn = 1'b0;
        enable = 1'b0;
        slot_valid = '0;
        ifs_cycles = 8'd3;
        timeout_cycles = 12'd10;
        lin_bus.comm_tx_done = 1'b0;
        lin_bus.resp_tx_done = 1'b0;
        lin_bus.resp_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            pid_a[i] = 6'(17 + 7 * i);
            len_a[i] = 4'(i + 1);
        end
        apply_cfg();
        m_ptr = 0; m_fc = 0; m_ec = 0;

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge sys_clk);
        chk("idle_when_disabled", sched_busy, 0);

        // Directed frame table: round-robin order, wrap, timeout, counters.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slot_valid = tbl[i].mask;
            e = next_slot(slot_valid, m_ptr);
            model_update(tbl[i].kind, e);
            run_frame(tbl[i].kind, 1 + (i % 2), 2, (i == 1 || i == 4), 1'b0, 1'b0,
                      tbl[i].exp_idx, tbl[i].exp_fc, tbl[i].exp_ec, 3);
        end

        // Response lands on the same cycle the timer expires: response wins.
        slot_valid = 4'b1111;
        e = next_slot(slot_valid, m_ptr);
        model_update(0, e);
        run_frame(0, 1, 9, 1'b0, 1'b0, 1'b0, e, m_fc, m_ec, 3);

        // enable dropped while waiting for the header: frame and gap still finish.
        e = next_slot(slot_valid, m_ptr);
        model_update(0, e);
        run_frame(0, 2, 2, 1'b0, 1'b1, 1'b0, e, m_fc, m_ec, 3);
        chk("idle_after_disable", sched_busy, 0);
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (lin_bus.start) starts++;
        end
        chk("no_start_when_disabled", starts, 0);
        chk("still_idle", sched_busy, 0);
        enable = 1'b1;

        // All slots invalidated while SELECT is evaluating: back to IDLE, no start.
        e = next_slot(slot_valid, m_ptr);
        model_update(0, e);
        run_frame(0, 1, 1, 1'b0, 1'b0, 1'b0, e, m_fc, m_ec, 3);
        slot_valid = '0;
        @(negedge sys_clk);
        chk("select_empty_idle", sched_busy, 0);
        starts = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (lin_bus.start) starts++;
        end
        chk("select_empty_no_start", starts, 0);
        slot_valid = 4'b1111;

        // Reset pulse while waiting for the response.
        wait_start(found);
        @(negedge sys_clk);
        lin_bus.comm_tx_done = 1'b1;
        @(negedge sys_clk);
        lin_bus.comm_tx_done = 1'b0;
        rstn = 1'b0;
        @(negedge sys_clk);
        check_all_zero("midframe_reset");
        rstn = 1'b1;
        m_ptr = 0; m_fc = 0; m_ec = 0;
        ifs_cycles = 8'd0;

        // 260 errored frames from a clean reset: err_count saturates.
        for (int f = 0; f < 260; f++) begin
            e = next_slot(slot_valid, m_ptr);
            if (f == 0) chk("first_slot_after_reset", e, 0);
            model_update(1, e);
            run_frame(1, 1, 1, 1'b0, 1'b0, 1'b0, e, m_fc, m_ec, 1);
        end
        chk("err_count_saturated", err_count, 255);
        chk("frame_count_260", frame_count, 260);

        // Randomized frames against the reference model.
        for (int f = 0; f < 150; f++) begin
            slot_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                pid_a[i] = 6'($urandom);
                len_a[i] = 4'($urandom_range(1, 8));
            end
            apply_cfg();
            ifs = int'($urandom_range(0, 4));
            ifs_cycles = 8'(ifs);
            case ($urandom_range(0, 3))
                0:       timeout_cycles = 12'd0;
                1:       timeout_cycles = 12'd10;
                2:       timeout_cycles = 12'd15;
                default: timeout_cycles = 12'd40;
            endcase
            kind = (timeout_cycles == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
            e = next_slot(slot_valid, m_ptr);
            model_update(kind, e);
            run_frame(kind, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)), 1'b0, 1'b1, e, m_fc, m_ec, (ifs > 0) ? ifs : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
